// File: rtl/seq_master_pkg.sv
// Shared opcode and FSM state encodings for the seq_master datapath master.
package seq_master_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_master_if.sv
// Command handshake and result bus of seq_master; slave is the block, master the issuer.
interface seq_master_if
    import seq_master_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_operand;
    logic [CNT_W-1:0] cmd_cnt;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             flag;
    logic             busy;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, cmd_cnt, abort,
        output cmd_ready, q, flag, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_operand, cmd_cnt, abort,
        input  cmd_ready, q, flag, busy, done
    );

endinterface

// File: rtl/seq_master_alu.sv
// Single-iteration operation on the accumulator: returns next value and the flag contribution.
module seq_master_alu
    import seq_master_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_q,
    output logic             flag_bit
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = {1'b0, q} + {1'b0, operand};
        next_q   = q;
        flag_bit = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_LOAD: next_q = operand;
            OP_ADD:  begin
                next_q   = sum[WIDTH-1:0];
                flag_bit = sum[WIDTH];
            end
            OP_SUB:  begin
                next_q   = q - operand;
                flag_bit = (operand > q);
            end
            OP_SHL:  begin
                next_q   = {q[WIDTH-2:0], 1'b0};
                flag_bit = q[WIDTH-1];
            end
            OP_SHR:  begin
                next_q   = {1'b0, q[WIDTH-1:1]};
                flag_bit = q[0];
            end
            OP_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_CLR:  next_q = '0;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_master.sv
// Command-driven accumulator master: accepts one command, runs it for N iterations, pulses done.
module seq_master
    import seq_master_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    seq_master_if.slave bus
);

    state_e           state, state_nxt;
    op_e              op_r;
    op_e              op_in;
    logic [WIDTH-1:0] operand_r;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] iters;
    logic [WIDTH-1:0] q_r;
    logic             flag_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] alu_q;
    logic             alu_flag;
    logic             ready;
    logic             accept;
    logic             step;

    assign ready = (state == ST_IDLE) && !rst;
    assign op_in = op_e'(bus.cmd_op);

    // LOAD and CLR always run once; a zero count also means one iteration
    assign iters = (op_in == OP_LOAD || op_in == OP_CLR || bus.cmd_cnt == '0)
                   ? CNT_W'(1) : bus.cmd_cnt;

    seq_master_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_r),
        .q        (q_r),
        .operand  (operand_r),
        .next_q   (alu_q),
        .flag_bit (alu_flag)
    );

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (rem == CNT_W'(1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= OP_NOP;
            operand_r <= '0;
            rem       <= '0;
            q_r       <= '0;
            flag_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_r <= (state_nxt == ST_EXEC);
            done_r <= (state_nxt == ST_DONE);
            if (accept) begin
                op_r      <= op_in;
                operand_r <= bus.cmd_operand;
                rem       <= iters;
                flag_r    <= 1'b0;
            end
            if (step) begin
                q_r    <= alu_q;
                flag_r <= (op_r == OP_CLR) ? 1'b0 : (flag_r | alu_flag);
                rem    <= rem - CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.q         = q_r;
    assign bus.flag      = flag_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_seq_master.sv
// Randomised bench for seq_master against a transaction-level accumulator model.
module tb_seq_master;
    import seq_master_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] q_m;
    logic       flag_m;

    always #5 clk = ~clk;

    seq_master_if #(.WIDTH(8), .CNT_W(4)) bus ();

    seq_master #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One iteration of the opcode on the model, in plain integer arithmetic
    task automatic model_step(input logic [2:0] op, input logic [7:0] opnd);
        int qi;
        int oi;
        qi = int'(q_m);
        oi = int'(opnd);
        case (op)
            3'd1: qi = oi;
            3'd2: begin
                if (qi + oi > 255) flag_m = 1'b1;
                qi = (qi + oi) % 256;
            end
            3'd3: begin
                if (oi > qi) flag_m = 1'b1;
                qi = (qi - oi + 256) % 256;
            end
            3'd4: begin
                if (qi >= 128) flag_m = 1'b1;
                qi = (qi * 2) % 256;
            end
            3'd5: begin
                if (qi % 2 == 1) flag_m = 1'b1;
                qi = qi / 2;
            end
            3'd6: qi = (qi * 2) % 256 + qi / 128;
            3'd7: begin
                qi     = 0;
                flag_m = 1'b0;
            end
            default: ;
        endcase
        q_m = 8'(qi);
    endtask

    // Issue one command from IDLE (called just after a falling edge) and check it cycle by cycle
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] opnd,
                           input logic [3:0] cnt, input int abort_at);
        int  n;
        bit  aborted;
        n       = (op == 3'd1 || op == 3'd7 || cnt == 4'd0) ? 1 : int'(cnt);
        aborted = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_operand = opnd;
        bus.cmd_cnt     = cnt;
        bus.abort       = 1'($urandom);
        #1;
        chk("ready_idle", 32'(bus.cmd_ready), 32'd1);
        flag_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // inputs after acceptance must not matter
        bus.cmd_valid   = 1'($urandom);
        bus.cmd_op      = 3'($urandom);
        bus.cmd_operand = 8'($urandom);
        bus.cmd_cnt     = 4'($urandom);
        for (int i = 1; i <= n; i++) begin
            chk("exec_busy",  32'(bus.busy),      32'd1);
            chk("exec_done",  32'(bus.done),      32'd0);
            chk("exec_ready", 32'(bus.cmd_ready), 32'd0);
            chk("exec_q",     32'(bus.q),         32'(q_m));
            chk("exec_flag",  32'(bus.flag),      32'(flag_m));
            bus.abort = (i == abort_at);
            if (i == abort_at) aborted = 1'b1;
            else model_step(op, opnd);
            @(negedge clk);
            if (aborted) break;
        end
        bus.abort = 1'b0;
        if (aborted) begin
            chk("abort_done",  32'(bus.done),      32'd0);
            chk("abort_busy",  32'(bus.busy),      32'd0);
            chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
            chk("abort_q",     32'(bus.q),         32'(q_m));
            chk("abort_flag",  32'(bus.flag),      32'(flag_m));
            bus.cmd_valid = 1'b0;
        end else begin
            chk("done_pulse", 32'(bus.done),      32'd1);
            chk("done_busy",  32'(bus.busy),      32'd0);
            chk("done_ready", 32'(bus.cmd_ready), 32'd0);
            chk("done_q",     32'(bus.q),         32'(q_m));
            chk("done_flag",  32'(bus.flag),      32'(flag_m));
            bus.abort = 1'($urandom);
            @(negedge clk);
            bus.abort = 1'b0;
            chk("post_done",  32'(bus.done),      32'd0);
            chk("post_ready", 32'(bus.cmd_ready), 32'd1);
            chk("post_q",     32'(bus.q),         32'(q_m));
            chk("post_flag",  32'(bus.flag),      32'(flag_m));
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_exec();
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'(OP_ADD);
        bus.cmd_operand = 8'h01;
        bus.cmd_cnt     = 4'd10;
        bus.abort       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_q",     32'(bus.q),         32'd0);
        chk("rst_flag",  32'(bus.flag),      32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_rel", 32'(bus.cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", 32'(bus.done), 32'd0);
            chk("rst_idle",    32'(bus.busy), 32'd0);
        end
        q_m    = 8'h00;
        flag_m = 1'b0;
    endtask

    initial begin
        int abort_at;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.cmd_operand = 8'h00;
        bus.cmd_cnt     = 4'd0;
        bus.abort       = 1'b0;
        q_m             = 8'h00;
        flag_m          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_q",     32'(bus.q),         32'd0);
        chk("reset_flag",  32'(bus.flag),      32'd0);
        chk("reset_busy",  32'(bus.busy),      32'd0);
        chk("reset_done",  32'(bus.done),      32'd0);
        chk("reset_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(3'(OP_LOAD), 8'h5A, 4'd0, 0);
        chk("plan_load_q", 32'(bus.q), 32'h5A);

        run_cmd(3'(OP_LOAD), 8'hF0, 4'd0, 0);
        run_cmd(3'(OP_ADD), 8'h20, 4'd3, 0);
        chk("plan_add_q",    32'(bus.q),    32'h50);
        chk("plan_add_flag", 32'(bus.flag), 32'd1);

        run_cmd(3'(OP_LOAD), 8'h81, 4'd0, 0);
        run_cmd(3'(OP_SHL), 8'h00, 4'd2, 0);
        chk("plan_shl_q",    32'(bus.q),    32'h04);
        chk("plan_shl_flag", 32'(bus.flag), 32'd1);
        run_cmd(3'(OP_ROL), 8'h00, 4'd8, 0);
        chk("plan_rol_q",    32'(bus.q),    32'h04);
        chk("plan_rol_flag", 32'(bus.flag), 32'd0);

        run_cmd(3'(OP_CLR), 8'h00, 4'd5, 0);
        run_cmd(3'(OP_SUB), 8'h01, 4'd1, 0);
        chk("plan_sub_q",    32'(bus.q),    32'hFF);
        chk("plan_sub_flag", 32'(bus.flag), 32'd1);
        run_cmd(3'(OP_CLR), 8'h00, 4'd0, 0);
        chk("plan_clr_q",    32'(bus.q),    32'h00);
        chk("plan_clr_flag", 32'(bus.flag), 32'd0);

        run_cmd(3'(OP_ADD), 8'h01, 4'd10, 4);
        chk("plan_abort_q", 32'(bus.q), 32'h03);

        run_cmd(3'(OP_SHR), 8'h00, 4'd15, 0);
        reset_mid_exec();

        for (int k = 0; k < 250; k++) begin
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            run_cmd(3'($urandom), 8'($urandom), 4'($urandom), abort_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
